pixel_frame_writer: RTL and testbench

PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

---
 rtl/pixel_frame_writer.sv | 164 ++++++++++++++++
 tb/tb_pixel_frame_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer
//   Streams pixels into a BRAM write port as whole frames. A base-address
//   strobe arms a frame. Each later valid pixel is written to base+offset,
//   one cycle after it arrives. The write with offset FRAME_PIXELS-1 closes
//   the frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   addr_axiiv   base-address valid strobe
//   addr_axiid   frame base address
//   pixel_axiiv  pixel valid strobe
//   pixel_axiid  pixel data
//   axiov        BRAM write enable (registered)
//   addr_axiod   BRAM write address (registered, holds when idle)
//   pixel_axiod  BRAM write data (registered, holds when idle)
//   frame_done   one-cycle pulse with the last write of a frame
//   frame_cnt    completed-frame count, wraps modulo 256
//   drop_err     sticky: a pixel arrived with no armed frame
//   abort_err    sticky: a frame was restarted before it completed
module pixel_frame_writer #(
  parameter int ADDR_WIDTH   = 24,
  parameter int PIXEL_WIDTH  = 8,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   addr_axiiv,
  input  logic [ADDR_WIDTH-1:0]  addr_axiid,
  input  logic                   pixel_axiiv,
  input  logic [PIXEL_WIDTH-1:0] pixel_axiid,
  output logic                   axiov,
  output logic [ADDR_WIDTH-1:0]  addr_axiod,
  output logic [PIXEL_WIDTH-1:0] pixel_axiod,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt,
  output logic                   drop_err,
  output logic                   abort_err
);

  localparam int OFF_W = $clog2(FRAME_PIXELS) + 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_PIXELS - 1);
  localparam logic [OFF_W-1:0] OFF_ZERO = {OFF_W{1'b0}};
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   base_r, base_s;
  logic [OFF_W-1:0]        offset_r, offset_s;
  logic                    wr_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic                    done_s;
  logic                    drop_s;
  logic                    abort_s;

  // Next-state, next-base/offset and write decision for the current cycle.
  always_comb begin
    state_s   = state_r;
    base_s    = base_r;
    offset_s  = offset_r;
    wr_s      = pixel_axiiv;
    // Truncation to ADDR_WIDTH gives the modulo-2^ADDR_WIDTH address wrap.
    wr_addr_s = base_r + ADDR_WIDTH'(offset_r);
    done_s    = 1'b0;
    drop_s    = 1'b0;
    abort_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (addr_axiiv) begin
          // A same-cycle pixel lands at the new base, offset 0.
          base_s    = addr_axiid;
          wr_addr_s = addr_axiid;
          state_s   = ACTIVE;
          if (pixel_axiiv) begin
            offset_s = OFF_ONE;
          end else begin
            offset_s = OFF_ZERO;
          end
        end else begin
          wr_s     = 1'b0;
          drop_s   = pixel_axiiv;
          offset_s = OFF_ZERO;
        end
      end

      ACTIVE: begin
        if (pixel_axiiv && (offset_r == LAST_OFF)) begin
          // The final pixel wins over a same-cycle base strobe. The frame
          // completes, and the new base only arms the next frame.
          done_s   = 1'b1;
          offset_s = OFF_ZERO;
          if (addr_axiiv) begin
            base_s  = addr_axiid;
            state_s = ACTIVE;
          end else begin
            state_s = IDLE;
          end
        end else if (addr_axiiv) begin
          // Restart of an incomplete frame.
          abort_s   = 1'b1;
          base_s    = addr_axiid;
          wr_addr_s = addr_axiid;
          if (pixel_axiiv) begin
            offset_s = OFF_ONE;
          end else begin
            offset_s = OFF_ZERO;
          end
        end else if (pixel_axiiv) begin
          offset_s = offset_r + OFF_ONE;
        end else begin
          offset_s = offset_r;
        end
      end

      default: begin
        state_s  = IDLE;
        wr_s     = 1'b0;
        offset_s = OFF_ZERO;
      end
    endcase
  end

  // FSM, frame context and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      base_r      <= {ADDR_WIDTH{1'b0}};
      offset_r    <= OFF_ZERO;
      axiov       <= 1'b0;
      addr_axiod  <= {ADDR_WIDTH{1'b0}};
      pixel_axiod <= {PIXEL_WIDTH{1'b0}};
      frame_done  <= 1'b0;
      frame_cnt   <= 8'd0;
      drop_err    <= 1'b0;
      abort_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      base_r     <= base_s;
      offset_r   <= offset_s;
      axiov      <= wr_s;
      frame_done <= done_s;
      drop_err   <= drop_err | drop_s;
      abort_err  <= abort_err | abort_s;
      if (wr_s) begin
        addr_axiod  <= wr_addr_s;
        pixel_axiod <= pixel_axiid;
      end else begin
        addr_axiod  <= addr_axiod;
        pixel_axiod <= pixel_axiod;
      end
      if (done_s) begin
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
module tb_pixel_frame_writer;

  logic        clk;
  logic        rst;
  logic        addr_axiiv;
  logic [23:0] addr_axiid;
  logic        pixel_axiiv;
  logic [7:0]  pixel_axiid;
  logic        axiov;
  logic [23:0] addr_axiod;
  logic [7:0]  pixel_axiod;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        drop_err;
  logic        abort_err;

  pixel_frame_writer #(
    .ADDR_WIDTH  (24),
    .PIXEL_WIDTH (8),
    .FRAME_PIXELS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_axiiv (addr_axiiv),
    .addr_axiid (addr_axiid),
    .pixel_axiiv(pixel_axiiv),
    .pixel_axiid(pixel_axiid),
    .axiov      (axiov),
    .addr_axiod (addr_axiod),
    .pixel_axiod(pixel_axiod),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .drop_err   (drop_err),
    .abort_err  (abort_err)
  );

  typedef struct packed {
    logic        ov;
    logic [23:0] oa;
    logic [7:0]  op;
    logic        done;
    logic [7:0]  cnt;
    logic        drop;
    logic        abort;
  } out_t;

  typedef struct {
    logic        av;
    logic [23:0] ad;
    logic        pv;
    logic [7:0]  pd;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  function automatic out_t mk_out(logic ov, logic [23:0] oa, logic [7:0] op, logic done,
                                  logic [7:0] cnt, logic drop, logic abort);
    out_t o;
    o = {ov, oa, op, done, cnt, drop, abort};
    return o;
  endfunction

  function automatic vec_t mk(logic av, logic [23:0] ad, logic pv, logic [7:0] pd, out_t e);
    vec_t v;
    v.av = av; v.ad = ad; v.pv = pv; v.pd = pd; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, out_t e);
    out_t a;
    a = {axiov, addr_axiod, pixel_axiod, frame_done, frame_cnt, drop_err, abort_err};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got ov=%b addr=%h pix=%h done=%b cnt=%0d drop=%b abort=%b, want ov=%b addr=%h pix=%h done=%b cnt=%0d drop=%b abort=%b",
               name, a.ov, a.oa, a.op, a.done, a.cnt, a.drop, a.abort,
               e.ov, e.oa, e.op, e.done, e.cnt, e.drop, e.abort);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(string name, logic av, logic [23:0] ad, logic pv, logic [7:0] pd, out_t e);
    out_t got_exp;
    exp_q.push_back(e);
    addr_axiiv  = av;
    addr_axiid  = ad;
    pixel_axiiv = pv;
    pixel_axiid = pd;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got_exp = exp_q.pop_front();
      chk(name, got_exp);
    end
  endtask

  task automatic do_reset();
    addr_axiiv  = 1'b0;
    addr_axiid  = 24'h0;
    pixel_axiiv = 1'b0;
    pixel_axiid = 8'h0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam out_t Z = '0;

  initial begin
    logic [7:0]  ecnt;
    logic [23:0] laddr;
    logic [7:0]  lpix;
    logic [23:0] fb;

    rst = 1'b1;
    do_reset();
    chk("reset_state", Z);

    // base 0x100, A0..A3 -> 0x100..0x103, done with last
    vecs.push_back(mk(1'b1, 24'h000100, 1'b0, 8'h00, mk_out(1'b0, 24'h000000, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hA0, mk_out(1'b1, 24'h000100, 8'hA0, 1'b0, 8'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hA1, mk_out(1'b1, 24'h000101, 8'hA1, 1'b0, 8'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hA2, mk_out(1'b1, 24'h000102, 8'hA2, 1'b0, 8'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hA3, mk_out(1'b1, 24'h000103, 8'hA3, 1'b1, 8'd1, 1'b0, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b0, 8'h00, mk_out(1'b0, 24'h000103, 8'hA3, 1'b0, 8'd1, 1'b0, 1'b0)));
    // dropped pixel, then base + pixel in same cycle
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'h55, mk_out(1'b0, 24'h000103, 8'hA3, 1'b0, 8'd1, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b1, 24'h000010, 1'b1, 8'h66, mk_out(1'b1, 24'h000010, 8'h66, 1'b0, 8'd1, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'h67, mk_out(1'b1, 24'h000011, 8'h67, 1'b0, 8'd1, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'h68, mk_out(1'b1, 24'h000012, 8'h68, 1'b0, 8'd1, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'h69, mk_out(1'b1, 24'h000013, 8'h69, 1'b1, 8'd2, 1'b1, 1'b0)));
    // address wrap
    vecs.push_back(mk(1'b1, 24'hFFFFFE, 1'b0, 8'h00, mk_out(1'b0, 24'h000013, 8'h69, 1'b0, 8'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hB0, mk_out(1'b1, 24'hFFFFFE, 8'hB0, 1'b0, 8'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hB1, mk_out(1'b1, 24'hFFFFFF, 8'hB1, 1'b0, 8'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hB2, mk_out(1'b1, 24'h000000, 8'hB2, 1'b0, 8'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hB3, mk_out(1'b1, 24'h000001, 8'hB3, 1'b1, 8'd3, 1'b1, 1'b0)));
    // base strobe with the final pixel: completes, no abort, re-arms
    vecs.push_back(mk(1'b1, 24'h000080, 1'b0, 8'h00, mk_out(1'b0, 24'h000001, 8'hB3, 1'b0, 8'd3, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hD0, mk_out(1'b1, 24'h000080, 8'hD0, 1'b0, 8'd3, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hD1, mk_out(1'b1, 24'h000081, 8'hD1, 1'b0, 8'd3, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hD2, mk_out(1'b1, 24'h000082, 8'hD2, 1'b0, 8'd3, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b1, 24'h000090, 1'b1, 8'hD3, mk_out(1'b1, 24'h000083, 8'hD3, 1'b1, 8'd4, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hE0, mk_out(1'b1, 24'h000090, 8'hE0, 1'b0, 8'd4, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hE1, mk_out(1'b1, 24'h000091, 8'hE1, 1'b0, 8'd4, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hE2, mk_out(1'b1, 24'h000092, 8'hE2, 1'b0, 8'd4, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hE3, mk_out(1'b1, 24'h000093, 8'hE3, 1'b1, 8'd5, 1'b1, 1'b0)));
    // abort mid-frame: restart at 0x40 with a same-cycle pixel
    vecs.push_back(mk(1'b1, 24'h000020, 1'b0, 8'h00, mk_out(1'b0, 24'h000093, 8'hE3, 1'b0, 8'd5, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hC0, mk_out(1'b1, 24'h000020, 8'hC0, 1'b0, 8'd5, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hC1, mk_out(1'b1, 24'h000021, 8'hC1, 1'b0, 8'd5, 1'b1, 1'b0)));
    vecs.push_back(mk(1'b1, 24'h000040, 1'b1, 8'hC2, mk_out(1'b1, 24'h000040, 8'hC2, 1'b0, 8'd5, 1'b1, 1'b1)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hC3, mk_out(1'b1, 24'h000041, 8'hC3, 1'b0, 8'd5, 1'b1, 1'b1)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b0, 8'hEE, mk_out(1'b0, 24'h000041, 8'hC3, 1'b0, 8'd5, 1'b1, 1'b1)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hC4, mk_out(1'b1, 24'h000042, 8'hC4, 1'b0, 8'd5, 1'b1, 1'b1)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'hC5, mk_out(1'b1, 24'h000043, 8'hC5, 1'b1, 8'd6, 1'b1, 1'b1)));
    vecs.push_back(mk(1'b0, 24'h0,      1'b1, 8'h77, mk_out(1'b0, 24'h000043, 8'hC5, 1'b0, 8'd6, 1'b1, 1'b1)));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].av, vecs[i].ad, vecs[i].pv, vecs[i].pd, vecs[i].exp);
    end

    // Reset mid-frame: outputs clear at once, later pixels are dropped.
    step("rst_base", 1'b1, 24'h000200, 1'b0, 8'h00, mk_out(1'b0, 24'h000043, 8'hC5, 1'b0, 8'd6, 1'b1, 1'b1));
    step("rst_px0",  1'b0, 24'h0,      1'b1, 8'hF0, mk_out(1'b1, 24'h000200, 8'hF0, 1'b0, 8'd6, 1'b1, 1'b1));
    step("rst_px1",  1'b0, 24'h0,      1'b1, 8'hF1, mk_out(1'b1, 24'h000201, 8'hF1, 1'b0, 8'd6, 1'b1, 1'b1));
    pixel_axiiv = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async", Z);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_hold", Z);
    step("rst_drop0", 1'b0, 24'h0, 1'b1, 8'hF2, mk_out(1'b0, 24'h0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0));
    step("rst_drop1", 1'b0, 24'h0, 1'b1, 8'hF3, mk_out(1'b0, 24'h0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0));

    // 256 frames with random gaps: frame_cnt returns to 0.
    do_reset();
    chk("reset2", Z);
    ecnt  = 8'd0;
    laddr = 24'h0;
    lpix  = 8'h0;
    for (int f = 0; f < 256; f++) begin
      fb = 24'(f * 16 + 24'h001000);
      step("frm_base", 1'b1, fb, 1'b0, 8'h00, mk_out(1'b0, laddr, lpix, 1'b0, ecnt, 1'b0, 1'b0));
      for (int k = 0; k < 4; k++) begin
        int gaps;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          step("frm_gap", 1'b0, 24'h0, 1'b0, 8'hFF, mk_out(1'b0, laddr, lpix, 1'b0, ecnt, 1'b0, 1'b0));
        end
        laddr = fb + 24'(k);
        lpix  = 8'(f + k * 64);
        if (k == 3) begin
          ecnt = ecnt + 8'd1;
        end
        step("frm_px", 1'b0, 24'h0, 1'b1, lpix, mk_out(1'b1, laddr, lpix, (k == 3), ecnt, 1'b0, 1'b0));
      end
    end
    chk("cnt_wrap", mk_out(1'b1, laddr, lpix, 1'b1, 8'd0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
